// File: rtl/dec3to8_stream.sv
// dec3to8_stream: streaming 3-to-8 one-hot decoder.
// A valid/ready code input feeds a 2-entry in-order output buffer of one-hot
// words. With en=0, accepted codes are counted and discarded.
// A sticky hit mask records every word delivered.
module dec3to8_stream #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       hit_mask,
  input  logic             clr_hist,
  output logic [CNT_W-1:0] drop_cnt
);

  // buffer storage and bookkeeping
  logic [1:0][7:0]  mem_q,  mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q,  occ_d;    // 0..2, separates full from empty
  logic [7:0]       hit_q,  hit_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic empty, full;
  logic in_hs, push, drop, pop;
  logic [7:0] onehot;

  assign empty  = (occ_q == 2'd0);
  assign full   = (occ_q == 2'd2);
  assign onehot = 8'h01 << in_code;

  // Dropped codes are always accepted, so en=0 never stalls the producer.
  // When full, in_ready stays low even if a pop happens this cycle.
  assign in_ready  = en ? !full : 1'b1;
  assign in_hs     = in_valid && in_ready;
  assign push      = in_hs && en;
  assign drop      = in_hs && !en;

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;

  assign hit_mask  = hit_q;
  assign drop_cnt  = drop_q;

  // next-state: buffer write/read, occupancy, hit history, drop counter
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    hit_d    = hit_q;
    drop_d   = drop_q;

    if (push) begin
      mem_d[wr_ptr_q] = onehot;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end

    // A push plus pop only occurs with one entry held; occupancy is unchanged.
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // A clear keeps whatever is delivered in the same cycle.
    if (clr_hist) begin
      hit_d = pop ? out_data : 8'h00;
    end else if (pop) begin
      hit_d = hit_q | out_data;
    end

    if (drop && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      hit_q    <= 8'h00;
      drop_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      hit_q    <= hit_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_dec3to8_stream.sv
// Self-checking bench for dec3to8_stream: a directed vector table plus
// hand sequences for combinational latency, reset and counter saturation.
module tb_dec3to8_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, in_valid, out_ready, clr_hist;
  logic [2:0] in_code;
  logic       in_ready, out_valid;
  logic [7:0] out_data, hit_mask;
  logic [7:0] drop_cnt;

  // second instance with a narrow counter for saturation
  logic       s_en, s_in_valid, s_out_ready, s_clr_hist;
  logic [2:0] s_in_code;
  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data, s_hit_mask;
  logic [1:0] s_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dec3to8_stream #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .hit_mask(hit_mask), .clr_hist(clr_hist),
    .drop_cnt(drop_cnt)
  );

  dec3to8_stream #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(s_en), .in_code(s_in_code), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .hit_mask(s_hit_mask), .clr_hist(s_clr_hist),
    .drop_cnt(s_drop_cnt)
  );

  typedef struct {
    logic       en, vld;
    logic [2:0] code;
    logic       ordy, clr;
    logic       rdy;      // in_ready expected before the edge
    logic       ov;       // out_valid after the edge
    logic [7:0] od;       // out_data after the edge
    logic [7:0] hit;      // hit_mask after the edge
    logic [7:0] drop;     // drop_cnt after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic e, input logic vl, input logic [2:0] c,
                             input logic o, input logic cl, input logic r,
                             input logic ovx, input logic [7:0] odx,
                             input logic [7:0] h, input logic [7:0] d);
    vec_t t;
    t.en = e; t.vld = vl; t.code = c; t.ordy = o; t.clr = cl;
    t.rdy = r; t.ov = ovx; t.od = odx; t.hit = h; t.drop = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one edge, then settle so sampling is away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 3'd0;
    out_ready = 1'b0; clr_hist = 1'b0;
    s_en = 1'b0; s_in_valid = 1'b0; s_in_code = 3'd0;
    s_out_ready = 1'b0; s_clr_hist = 1'b0;

    // back-to-back decode of 0..7 with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      logic [7:0] one, prev;
      one  = 8'h01 << i;
      prev = one - 8'h01;
      tbl.push_back(v(1, 1, 3'(i), 1, 0, 1, 1, one, prev, 8'd0));
    end
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 8'h00, 8'hFF, 8'd0));
    // back-pressure: 3 and 5 fill the buffer, 6 waits for space
    tbl.push_back(v(1, 1, 3, 0, 0, 1, 1, 8'h08, 8'hFF, 8'd0));
    tbl.push_back(v(1, 1, 5, 0, 0, 1, 1, 8'h08, 8'hFF, 8'd0));
    tbl.push_back(v(1, 1, 6, 0, 0, 0, 1, 8'h08, 8'hFF, 8'd0));
    tbl.push_back(v(1, 1, 6, 1, 0, 0, 1, 8'h20, 8'hFF, 8'd0));
    tbl.push_back(v(1, 1, 6, 1, 0, 1, 1, 8'h40, 8'hFF, 8'd0));
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 8'h00, 8'hFF, 8'd0));
    // five drops with en=0
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 1, 3'(i), 1, 0, 1, 0, 8'h00, 8'hFF, 8'(i + 1)));
    // clear with no handshake, then push/pop at occupancy 1
    tbl.push_back(v(1, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'd5));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 1, 8'h01, 8'h00, 8'd5));
    tbl.push_back(v(1, 1, 2, 1, 0, 1, 1, 8'h04, 8'h01, 8'd5));
    tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 8'h00, 8'h05, 8'd5));
    // build hit=0C, then clear in the cycle 01 is delivered
    tbl.push_back(v(1, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'd5));
    tbl.push_back(v(1, 1, 2, 0, 0, 1, 1, 8'h04, 8'h00, 8'd5));
    tbl.push_back(v(1, 1, 3, 1, 0, 1, 1, 8'h08, 8'h04, 8'd5));
    tbl.push_back(v(1, 1, 0, 1, 0, 1, 1, 8'h01, 8'h0C, 8'd5));
    tbl.push_back(v(1, 0, 0, 1, 1, 1, 0, 8'h00, 8'h01, 8'd5));
    tbl.push_back(v(1, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'd5));
    // fill, drop while full (en=0 ignores full), then stall held
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 1, 8'h02, 8'h00, 8'd5));
    tbl.push_back(v(1, 1, 4, 0, 0, 1, 1, 8'h02, 8'h00, 8'd5));
    tbl.push_back(v(0, 1, 7, 0, 0, 1, 1, 8'h02, 8'h00, 8'd6));
    tbl.push_back(v(1, 1, 7, 0, 0, 0, 1, 8'h02, 8'h00, 8'd6));

    // reset state
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_hit_mask", hit_mask, 8'h00);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // no combinational in-to-out path: an offered code is not visible yet
    in_valid = 1'b1; in_code = 3'd4; out_ready = 1'b0;
    #1;
    check("no_comb_path_valid", out_valid, 0);
    check("no_comb_path_data", out_data, 8'h00);
    tick();
    check("latency_one_cycle", out_data, 8'h10);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("drain_after_latency", out_valid, 0);
    clr_hist = 1'b1;
    tick();
    clr_hist = 1'b0;

    foreach (tbl[k]) begin
      en = tbl[k].en; in_valid = tbl[k].vld; in_code = tbl[k].code;
      out_ready = tbl[k].ordy; clr_hist = tbl[k].clr;
      #1;
      check($sformatf("v%0d_in_ready", k), in_ready, tbl[k].rdy);
      tick();
      check($sformatf("v%0d_out_valid", k), out_valid, tbl[k].ov);
      check($sformatf("v%0d_out_data", k), out_data, tbl[k].od);
      check($sformatf("v%0d_hit_mask", k), hit_mask, tbl[k].hit);
      check($sformatf("v%0d_drop_cnt", k), drop_cnt, tbl[k].drop);
    end

    // reset with a full buffer: nothing stale comes out afterwards
    in_valid = 1'b0; en = 1'b1; out_ready = 1'b0; clr_hist = 1'b0;
    check("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_hit_mask", hit_mask, 8'h00);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_idle%0d", i), out_valid, 0);
      check($sformatf("post_rst_hit%0d", i), hit_mask, 8'h00);
    end

    // saturating drop counter, CNT_W=2
    s_en = 1'b0; s_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp_sat;
      s_in_code = 3'(i);
      #1;
      check($sformatf("sat_in_ready%0d", i), s_in_ready, 1);
      tick();
      exp_sat = (i < 3) ? 2'(i + 1) : 2'd3;
      check($sformatf("sat_drop%0d", i), s_drop_cnt, exp_sat);
      check($sformatf("sat_out_valid%0d", i), s_out_valid, 0);
    end
    s_in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // overall time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dec3to8_stream.md
Name: dec3to8_stream

Overview:
- Streaming 3-to-8 one-hot decoder: the inverse of the team's 8-to-3 encoder.
- Accepts 3-bit codes over a valid/ready handshake and emits the matching 8-bit one-hot word over a valid/ready handshake.
- Has a 2-entry output buffer, an enable gate that drops codes (with a drop counter), and a sticky hit-history mask.
- Sits between code producers (encoder outputs, command decoders) and one-hot select consumers.

Parameters:
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  decode enable; when 0, accepted codes are dropped
- in_code  input  3  binary code, 0..7
- in_valid  input  1  in_code valid
- in_ready  output  1  block can accept in_code this cycle
- out_data  output  8  one-hot word for the buffer head
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- hit_mask  output  8  sticky OR of every one-hot word delivered
- clr_hist  input  1  synchronous clear of hit_mask
- drop_cnt  output  CNT_W  number of codes dropped while en=0, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n and is sampled only at the clk rising edge.
- Reset values: buffer empty, out_valid=0, out_data=8'h00, hit_mask=8'h00, drop_cnt=0. in_ready=1 combinationally once the buffer is empty.
- Reset mid-operation: buffered words are discarded without delivery. Counters and mask clear on the same edge.
- Input accept: an input handshake occurs when in_valid && in_ready at a rising edge.
- in_ready:
  - Equals !full when en=1.
  - Equals 1 when en=0. Dropped codes never back-pressure.
- en=1 accept: write one-hot (8'h01 << in_code) into the buffer tail.
- Latency: a word written at edge N is visible at the buffer head from cycle N+1 when the buffer was empty. No combinational in-to-out path.
- en=0 accept:
  - Nothing is written.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1; no wrap.
- Buffered words drain regardless of en.
- Buffer:
  - 2-entry FIFO, strictly in order. out_valid = !empty. out_data = head word, or 8'h00 when empty.
  - Output handshake occurs when out_valid && out_ready; it pops the head.
  - Push and pop in the same cycle: allowed when 1 entry is held (occupancy stays 1, order kept) or when 0 entries are held is impossible (no pop).
  - Full (2 entries): in_ready=0 when en=1, even if out_ready=1 this cycle. No pass-through.
  - Pointers are 1 bit and wrap; a separate occupancy count (0..2) disambiguates full from empty.
- out_data and out_valid are stable while out_valid=1 and out_ready=0 (AXI-style hold).
- hit_mask:
  - On each output handshake, hit_mask <= hit_mask | out_data.
  - clr_hist=1: hit_mask <= (handshake ? out_data : 8'h00). Bits delivered in the clear cycle survive.
- Invariant: out_data always has exactly one bit set while out_valid=1. in_code values are all legal (3 bits), so there is no error path.
- en toggling while codes are pending upstream: the en value at the accepting edge decides keep or drop.

Test Plan:
- Reset, then drive in_code=0..7 back-to-back with out_ready=1, en=1 -> out_data sequence 01,02,04,08,10,20,40,80, each one cycle after accept; hit_mask=FF; drop_cnt=0.
- out_ready=0, push codes 3,5,6 -> first two accepted, in_ready=0 after the second; out_data holds 08. Raise out_ready -> 08 then 20 delivered; code 6 accepted once space frees, then 40.
- Occupancy 1 with simultaneous push of 2 and pop of head 01 -> next head 04, occupancy stays 1, no loss or reordering.
- en=0, push 5 codes -> in_ready=1 throughout, out_valid stays 0, drop_cnt=5. With CNT_W=2, push 6 drops -> drop_cnt sticks at 3.
- hit_mask=0x0C, assert clr_hist in the same cycle as delivery of 0x01 -> hit_mask=0x01 next cycle. clr_hist with no handshake -> 0x00.
- Buffer full (2 entries), assert rst_n=0 for one edge -> out_valid=0, out_data=00, drop_cnt=0, hit_mask=00; no stale word appears after reset.
